// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM encodings, line levels and parity helpers shared by the UART TX/RX blocks
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    function automatic logic parity_of(input logic red_xor, input logic typ);
        return (typ == PAR_EVEN) ? red_xor : ~red_xor;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: load/shift register and bit counter for the TX data phase
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] p_data,
    output logic                  ser_data,
    output logic                  ser_done
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    assign ser_data = shreg_q[0];
    assign ser_done = (cnt_q == CW'(DATA_WIDTH - 1));

    // Counter sits at zero outside DATA so it is already cleared on entry
    always_comb begin
        shreg_d = load ? p_data : (shift ? (shreg_q >> 1) : shreg_q);
        cnt_d   = shift ? (ser_done ? cnt_q : cnt_q + 1'b1) : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: frame FSM, parity and registered line driver for the UART transmit path
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);
    tx_state_e state_q, state_d;
    logic      tx_q, tx_d;
    logic      busy_q, busy_d;
    logic      par_q, par_d;
    logic      par_en_q, par_en_d;
    logic      accept, ser_data, ser_done;

    assign accept = Data_Valid && (state_q == IDLE || state_q == STOP);

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load     (accept),
        .shift    (state_q == DATA),
        .p_data   (P_DATA),
        .ser_data (ser_data),
        .ser_done (ser_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? START : IDLE;
            START:   state_d = DATA;
            DATA:    state_d = ser_done ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_d = STOP;
            STOP:    state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
        par_d    = accept ? parity_of(^P_DATA, PAR_TYP) : par_q;
        par_en_d = accept ? PAR_EN : par_en_q;
        // Line and Busy are registered from the current state, one cycle behind the FSM
        tx_d     = (state_q == START)  ? START_BIT :
                   (state_q == DATA)   ? ser_data  :
                   (state_q == PARITY) ? par_q     : STOP_BIT;
        busy_d   = (state_q != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            tx_q     <= STOP_BIT;
            busy_q   <= 1'b0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks for uart_tx against hand-computed line sequences
module tb_uart_tx;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT, Busy;
    int         checks = 0;
    int         errors = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check($sformatf("%s_tx%0d", tag, i), 32'(TX_OUT), 32'd1);
            check($sformatf("%s_busy%0d", tag, i), 32'(Busy), 32'd0);
        end
    endtask

    // exp lists line bits in transmit order, leftmost first; inputs are scrambled after acceptance
    task automatic frame(input string tag, input logic [7:0] d, input logic pen, input logic ptyp,
                         input logic [0:10] exp, input int n, input int pulse_at);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0; P_DATA = ~d; PAR_EN = ~pen; PAR_TYP = ~ptyp;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check($sformatf("%s_bit%0d", tag, i), 32'(TX_OUT), 32'(exp[i]));
            check($sformatf("%s_busy%0d", tag, i), 32'(Busy), 32'd1);
            Data_Valid = (i == pulse_at);
        end
        Data_Valid = 1'b0;
        expect_idle({tag, "_end"}, 3);
    endtask

    initial begin
        logic [0:9] b1, b2;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            P_DATA = 8'($urandom); Data_Valid = 1'($urandom);
            PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
            check($sformatf("rst_tx%0d", i), 32'(TX_OUT), 32'd1);
            check($sformatf("rst_busy%0d", i), 32'(Busy), 32'd0);
        end
        Data_Valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        expect_idle("post_rst", 3);

        frame("a5_np",   8'hA5, 1'b0, 1'b0, 11'b01010010111, 10, -1);
        frame("a5_even", 8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, -1);
        frame("a5_odd",  8'hA5, 1'b1, 1'b1, 11'b01010010111, 11, -1);
        frame("00_odd",  8'h00, 1'b1, 1'b1, 11'b00000000011, 11, 3);
        frame("ff_even", 8'hFF, 1'b1, 1'b0, 11'b01111111101, 11, 5);

        b1 = 10'b0001111001;
        b2 = 10'b0110000111;
        @(negedge CLK);
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check($sformatf("b2b1_bit%0d", i), 32'(TX_OUT), 32'(b1[i]));
            check($sformatf("b2b1_busy%0d", i), 32'(Busy), 32'd1);
            if (i == 8) P_DATA = 8'hC3;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check($sformatf("b2b2_bit%0d", i), 32'(TX_OUT), 32'(b2[i]));
            check($sformatf("b2b2_busy%0d", i), 32'(Busy), 32'd1);
            Data_Valid = 1'b0;
        end
        expect_idle("b2b_end", 3);

        @(negedge CLK);
        P_DATA = 8'h00; PAR_EN = 1'b0; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check($sformatf("mid_bit%0d", i), 32'(TX_OUT), 32'd0);
        end
        #2 RST = 1'b0;
        #1;
        check("mid_rst_tx", 32'(TX_OUT), 32'd1);
        check("mid_rst_busy", 32'(Busy), 32'd0);
        expect_idle("mid_hold", 2);
        RST = 1'b1;
        expect_idle("mid_rel", 3);
        frame("5a_np", 8'h5A, 1'b0, 1'b0, 11'b00101101011, 10, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
